// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for skid-buffered pipeline stages: state encoding,
// default bubble payload and an occupancy decode helper.
package pipe_skid_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  // Default payload width and bubble (NOP) payload shared by all stage instances
  localparam int unsigned STAGE_DATA_W = 32;
  localparam logic [STAGE_DATA_W-1:0] NOP_PAYLOAD = '0;

  // Number of live entries held in a given state
  function automatic logic [1:0] occ_of(state_e s);
    case (s)
      ST_FULL: occ_of = 2'd1;
      ST_SKID: occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_stage_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear, else increment unless already at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                   cnt_d = '0;
    else if (inc && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid-buffered pipeline stage. in_ready is decoded purely from
// the state register so no combinational path runs from out_ready back to
// in_ready; the skid register absorbs the one payload accepted while the
// downstream stalls. flush returns the stage to a clean bubble.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int unsigned        DATA_W   = 32,
  parameter logic [DATA_W-1:0]  NOP_DATA = DATA_W'(NOP_PAYLOAD),
  parameter int unsigned        CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  state_e            state_q;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              in_fire;
  logic              out_fire;

  assign in_ready  = (state_q != ST_SKID);
  assign out_valid = (state_q != ST_EMPTY);
  assign occupancy = occ_of(state_q);
  assign out_data  = main_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Stage FSM with main/skid payload registers; main is reloaded with the
  // bubble whenever the stage drains so out_data reads NOP while empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= NOP_DATA;
      skid_q  <= NOP_DATA;
    end else if (flush) begin
      state_q <= ST_EMPTY;
      main_q  <= NOP_DATA;
      skid_q  <= NOP_DATA;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_q  <= in_data;
            state_q <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            main_q <= in_data;
          end else if (in_fire) begin
            skid_q  <= in_data;
            state_q <= ST_SKID;
          end else if (out_fire) begin
            main_q  <= NOP_DATA;
            state_q <= ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_fire) begin
            main_q  <= skid_q;
            skid_q  <= NOP_DATA;
            state_q <= ST_FULL;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
          main_q  <= NOP_DATA;
          skid_q  <= NOP_DATA;
        end
      endcase
    end
  end

  // Starvation counter: downstream ready but nothing to give it
  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_ready & ~out_valid),
    .clr   (cnt_clr),
    .cnt   (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: a queue-based model of the stage (a two-deep
// FIFO plus starvation counters) checked against the DUT every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_pipe_skid_stage;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          flush = 1'b0;
  logic          cnt_clr = 1'b0;

  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [15:0]   bubble_cnt;

  logic          in_ready2, out_valid2;
  logic [DW-1:0] out_data2;
  logic [1:0]    occupancy2;
  logic [1:0]    bubble_cnt2;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model state
  logic [DW-1:0] mq[$];
  int            mcnt16 = 0;
  int            mcnt2  = 0;

  always #5 clk = ~clk;

  pipe_skid_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .flush(flush), .cnt_clr(cnt_clr),
    .occupancy(occupancy), .bubble_cnt(bubble_cnt)
  );

  pipe_skid_stage #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .flush(flush), .cnt_clr(cnt_clr),
    .occupancy(occupancy2), .bubble_cnt(bubble_cnt2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of at most two entries, updated on each edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mcnt16 = 0;
      mcnt2  = 0;
    end else begin
      automatic int  sz    = mq.size();
      automatic bit  ofire = (sz > 0) && out_ready;
      automatic bit  ifire = in_valid && (sz < 2);
      automatic bit  starv = out_ready && (sz == 0);
      if (flush) mq.delete();
      else begin
        if (ofire) void'(mq.pop_front());
        if (ifire) mq.push_back(in_data);
      end
      if (cnt_clr) begin
        mcnt16 = 0; mcnt2 = 0;
      end else if (starv) begin
        if (mcnt16 < 65535) mcnt16++;
        if (mcnt2 < 3)      mcnt2++;
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      automatic int            sz  = mq.size();
      automatic logic [DW-1:0] exd = (sz > 0) ? mq[0] : '0;
      check("out_valid", 64'(out_valid), 64'(sz > 0));
      check("in_ready",  64'(in_ready),  64'(sz < 2));
      check("occupancy", 64'(occupancy), 64'(sz));
      check("out_data",  64'(out_data),  64'(exd));
      check("bubble16",  64'(bubble_cnt), 64'(mcnt16));
      check("bubble2",   64'(bubble_cnt2), 64'(mcnt2));
      check("out_data2", 64'(out_data2), 64'(exd));
    end
  end

  // Apply inputs (called at a negedge) and advance to the next negedge
  task automatic cyc(input bit v, input logic [DW-1:0] d, input bit ordy,
                     input bit fl = 1'b0, input bit clr = 1'b0);
    in_valid = v; in_data = d; out_ready = ordy; flush = fl; cnt_clr = clr;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    // reset state
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_occ",       64'(occupancy), 64'd0);
    check("rst_bubble",    64'(bubble_cnt), 64'd0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // streaming: one-cycle latency, full throughput
    cyc(1, 32'h11, 1);
    check("stream_d0", 64'(out_data), 64'h11);
    check("stream_rdy0", 64'(in_ready), 64'd1);
    cyc(1, 32'h22, 1);
    check("stream_d1", 64'(out_data), 64'h22);
    cyc(1, 32'h33, 1);
    check("stream_d2", 64'(out_data), 64'h33);
    check("stream_rdy2", 64'(in_ready), 64'd1);
    cyc(0, 32'h0, 1);
    check("stream_empty_nop", 64'(out_data), 64'h0);

    // backpressure into the skid register
    cyc(1, 32'hA0, 0);
    cyc(1, 32'hB0, 0);
    check("bp_occ", 64'(occupancy), 64'd2);
    check("bp_rdy", 64'(in_ready), 64'd0);
    check("bp_head", 64'(out_data), 64'hA0);
    cyc(0, 32'h0, 1);
    check("bp_second", 64'(out_data), 64'hB0);
    check("bp_rdy_back", 64'(in_ready), 64'd1);
    cyc(0, 32'h0, 1);
    check("bp_drained", 64'(out_valid), 64'd0);

    // flush while SKID with a same-cycle offer
    cyc(1, 32'hC0, 0);
    cyc(1, 32'hD0, 0);
    cyc(1, 32'hE0, 0, 1);
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_data", 64'(out_data), 64'h0);
    check("fl_occ", 64'(occupancy), 64'd0);
    cyc(0, 32'h0, 1);
    check("fl_no_e0", 64'(out_valid), 64'd0);

    // starvation counter and saturation
    cyc(0, 32'h0, 1, 0, 1);
    check("cnt_clr0", 64'(bubble_cnt), 64'd0);
    repeat (5) cyc(0, 32'h0, 1);
    check("cnt_5", 64'(bubble_cnt), 64'd5);
    cyc(0, 32'h0, 1, 0, 1);
    check("cnt_clr_prio", 64'(bubble_cnt), 64'd0);
    repeat (10) cyc(0, 32'h0, 1);
    check("cnt_16b_10", 64'(bubble_cnt), 64'd10);
    check("cnt_2b_sat", 64'(bubble_cnt2), 64'd3);

    // asynchronous reset while SKID
    cyc(1, 32'h71, 0);
    cyc(1, 32'h72, 0);
    check("ar_pre_occ", 64'(occupancy), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 64'(out_valid), 64'd0);
    check("ar_occ", 64'(occupancy), 64'd0);
    check("ar_rdy", 64'(in_ready), 64'd1);
    check("ar_cnt", 64'(bubble_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 32'h55, 1);
    check("ar_first_accept", 64'(out_data), 64'h55);
    check("ar_first_valid", 64'(out_valid), 64'd1);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 9) < 6), $urandom, ($urandom_range(0, 9) < 6),
          ($urandom_range(0, 29) == 0), ($urandom_range(0, 39) == 0));
    end
    cyc(0, 32'h0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, payload width in bits (e.g. packed op/sel/num1/num2/dest/wen/delay-slot/link fields).
REQ-002 SHALL have parameter NOP_DATA, default all-zero of DATA_W, bubble payload loaded on reset and flush.
REQ-003 SHALL have parameter CNT_W, default 16, starvation counter width.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  upstream offers in_data.
REQ-007 SHALL have port in_ready  output  1  stage can accept; in fire = in_valid & in_ready.
REQ-008 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-009 SHALL have port out_valid  output  1  out_data is a live instruction.
REQ-010 SHALL have port out_ready  input  1  downstream accepts; out fire = out_valid & out_ready.
REQ-011 SHALL have port out_data  output  DATA_W  payload to next stage.
REQ-012 SHALL have port flush  input  1  discard all held and incoming payloads (exception/redirect).
REQ-013 SHALL have port cnt_clr  input  1  synchronous clear of bubble_cnt.
REQ-014 SHALL have port occupancy  output  2  number of held entries, 0..2.
REQ-015 SHALL have port bubble_cnt  output  CNT_W  cycles downstream was starved.

Function
REQ-016 SHALL hold a main register (drives out_data) and a skid register, with FSM states EMPTY, FULL, SKID.
REQ-017 SHALL drive in_ready = 1 in EMPTY and FULL, 0 in SKID, decoded from state register only (no combinational path from out_ready).
REQ-018 SHALL drive out_valid = 1 in FULL and SKID, 0 in EMPTY; occupancy = 0/1/2 for EMPTY/FULL/SKID.
REQ-019 EMPTY: in fire -> main<=in_data, go FULL; else stay.
REQ-020 FULL: in fire and out fire -> main<=in_data, stay FULL; in fire only -> skid<=in_data, go SKID; out fire only -> go EMPTY; neither -> hold.
REQ-021 SKID: out fire -> main<=skid, go FULL; else hold both registers.
REQ-022 Latency SHALL be exactly 1 cycle from in fire in EMPTY to out_valid; throughput 1 per cycle while out_ready stays 1.
REQ-023 Ordering SHALL be strict FIFO; no payload duplicated or dropped except by flush.
REQ-024 flush SHALL take priority over every other event: next state EMPTY, main and skid <= NOP_DATA, any same-cycle in fire discarded.
REQ-025 out_data SHALL equal NOP_DATA whenever state is EMPTY.
REQ-026 bubble_cnt SHALL increment by 1 each cycle with out_ready=1 and out_valid=0, saturating at 2^CNT_W-1.
REQ-027 cnt_clr SHALL zero bubble_cnt next cycle and take priority over increment; flush SHALL NOT affect bubble_cnt.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state EMPTY, main and skid to NOP_DATA, bubble_cnt to 0; hence out_valid=0, in_ready=1, occupancy=0.
REQ-029 Reset asserted mid-transfer SHALL discard both entries; first accept after release occurs on the first rising edge with rst_n=1.

Structure
REQ-030 Shared package SHALL hold the state encoding (EMPTY=2'd0, FULL=2'd1, SKID=2'd2) and the default NOP payload constant used across pipeline-stage instances.
REQ-031 Saturating counter SHALL be a sub-module sat_counter (parameter width; inc, clr inputs); the rest stays in one module.

Verification
REQ-032 Streaming: out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 on the next three cycles, in_ready constantly 1.
REQ-033 Backpressure: FULL with 0xA0, out_ready=0, push 0xB0 -> SKID, in_ready=0, occupancy=2; raise out_ready -> 0xA0 then 0xB0 delivered, in_ready returns 1 after the first out fire.
REQ-034 Flush: SKID with 0xC0/0xD0, assert flush with in_valid=1 (0xE0) -> next cycle EMPTY, out_data=NOP_DATA, 0xE0 never appears at output.
REQ-035 Counter: EMPTY, out_ready=1, in_valid=0 for 5 cycles -> bubble_cnt=5; cnt_clr plus another starved cycle -> 0; CNT_W=2 run 10 starved cycles -> holds at 3.
REQ-036 Async reset: assert rst_n=0 between clock edges while SKID -> out_valid=0, occupancy=0 immediately, without a clock edge.
